mlp_mac_node_seq: RTL

- Parametrised, time-multiplexed two-layer MAC node for the GNN datapath: y = ReLU(W1·x), out = W2·y, with optional output ReLU.
- Generalises the fixed 4-in / 4-hidden / 2-out MAC node to arbitrary input, hidden and output counts. Adds the output layer, a valid/ready handshake, backpressure and synchronous reset.
- Uses a single shared signed multiplier-accumulator stepped by counters. It sits between the feature-fetch stage and the aggregation stage.

---
 rtl/mlp_mac_node_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mlp_mac_node_seq.sv
// Time-multiplexed two-layer MAC node: out = [ReLU](W2 * ReLU(W1 * x)) on one shared signed MAC.
// Latency: out_valid rises N_IN*N_HID + N_HID*N_OUT + 1 cycles after the input handshake.
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready is seen.
module mlp_mac_node_seq #(
  parameter int IN_SIZE = 5,
  parameter int N_IN    = 4,
  parameter int N_HID   = 4,
  parameter int N_OUT   = 2,
  parameter int HID_W   = 2*IN_SIZE + $clog2(N_IN),
  parameter int OUT_W   = HID_W + IN_SIZE + $clog2(N_HID)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_IN*IN_SIZE-1:0]        x,
  input  logic [N_IN*N_HID*IN_SIZE-1:0]  w1,
  input  logic [N_HID*N_OUT*IN_SIZE-1:0] w2,
  input  logic                           relu_out_en,
  output logic [N_OUT*OUT_W-1:0]         out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_HID - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  state_t state, state_nxt;

  logic [N_IN*IN_SIZE-1:0]        x_r;
  logic [N_IN*N_HID*IN_SIZE-1:0]  w1_r;
  logic [N_HID*N_OUT*IN_SIZE-1:0] w2_r;
  logic                           relu_r;
  logic [IW-1:0]                  i_cnt;
  logic [JW-1:0]                  j_cnt;
  logic [KW-1:0]                  k_cnt;
  logic signed [OUT_W-1:0]        acc;
  logic signed [HID_W-1:0]        hid [N_HID];
  logic [N_OUT*OUT_W-1:0]         out_r;
  logic                           out_valid_r;

  logic signed [IN_SIZE-1:0]      x_e, w1_e, w2_e;
  logic signed [HID_W-1:0]        hid_e;
  logic signed [OUT_W-1:0]        mul_a, mul_b, prod, sum;
  logic signed [HID_W-1:0]        hid_val;
  logic signed [OUT_W-1:0]        out_val;

  logic i_wrap, j_wrap, k_wrap;

  assign i_wrap    = (i_cnt == I_LAST);
  assign j_wrap    = (j_cnt == J_LAST);
  assign k_wrap    = (k_cnt == K_LAST);
  assign in_ready  = (state == IDLE);
  assign busy      = (state == L1) || (state == L2);
  assign out       = out_r;
  assign out_valid = out_valid_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: each layer ends when its outer counter wraps.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)                  state_nxt = L1;
      L1:   if (i_wrap && j_wrap)          state_nxt = L2;
      L2:   if (j_wrap && k_wrap)          state_nxt = DONE;
      DONE: if (out_valid_r && out_ready)  state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Operand select for the shared multiplier; both layers run at OUT_W so one MAC serves both.
  always_comb begin
    x_e     = x_r[i_cnt*IN_SIZE +: IN_SIZE];
    w1_e    = w1_r[(j_cnt*N_IN + i_cnt)*IN_SIZE +: IN_SIZE];
    w2_e    = w2_r[(k_cnt*N_HID + j_cnt)*IN_SIZE +: IN_SIZE];
    hid_e   = hid[j_cnt];
    mul_a   = (state == L2) ? OUT_W'(hid_e) : OUT_W'(x_e);
    mul_b   = (state == L2) ? OUT_W'(w2_e)  : OUT_W'(w1_e);
    prod    = mul_a * mul_b;
    sum     = acc + prod;
    hid_val = sum[OUT_W-1] ? '0 : sum[HID_W-1:0];
    out_val = (relu_r && sum[OUT_W-1]) ? '0 : sum;
  end

  // Datapath: capture on handshake, accumulate per layer, publish and hold the result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r         <= '0;
      w1_r        <= '0;
      w2_r        <= '0;
      relu_r      <= 1'b0;
      i_cnt       <= '0;
      j_cnt       <= '0;
      k_cnt       <= '0;
      acc         <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      for (int n = 0; n < N_HID; n++) hid[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r    <= x;
            w1_r   <= w1;
            w2_r   <= w2;
            relu_r <= relu_out_en;
            i_cnt  <= '0;
            j_cnt  <= '0;
            k_cnt  <= '0;
            acc    <= '0;
          end
        end
        L1: begin
          if (i_wrap) begin
            hid[j_cnt] <= hid_val;
            acc        <= '0;
            i_cnt      <= '0;
            j_cnt      <= j_wrap ? '0 : j_cnt + 1'b1;
          end else begin
            acc        <= sum;
            i_cnt      <= i_cnt + 1'b1;
          end
        end
        L2: begin
          if (j_wrap) begin
            out_r[k_cnt*OUT_W +: OUT_W] <= out_val;
            acc   <= '0;
            j_cnt <= '0;
            k_cnt <= k_wrap ? '0 : k_cnt + 1'b1;
          end else begin
            acc   <= sum;
            j_cnt <= j_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!out_valid_r)   out_valid_r <= 1'b1;
          else if (out_ready) out_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
